branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Parametrised successor of the combinational next-PC branch selector: owns the architectural PC register and resolves unconditional (B), compare-and-branch (CBZ/CBNZ) and flag-conditional (B.cond) branches.
- Sits between decode/execute and instruction fetch. Provides the registered fetch PC, a one-cycle flush pulse on redirect, a sticky misaligned-target flag, and saturating branch/taken counters.

Parameters:
- XLEN, 64, width of PC, offset and compare operand
- SHIFT, 2, left shift applied to the sign-extended offset (word-addressed targets)
- INC, 4, sequential PC increment
- ALIGN, 2, target must have ALIGN low bits zero
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  freeze PC and ignore the current branch request
- br_valid  in  1  branch-resolution slot holds a valid instruction
- br_type  in  3  0 none, 1 B, 2 CBZ, 3 CBNZ, 4 B.cond, 5–7 treated as none
- br_cond  in  4  LEGv8 condition code for B.cond
- flags  in  4  {N,Z,C,V} from the flag register
- cmp_val  in  XLEN  register operand for CBZ/CBNZ
- pc_cur  in  XLEN  PC of the instruction being resolved
- se_off  in  XLEN  sign-extended branch offset, unshifted
- pc  out  XLEN  registered fetch PC
- flush  out  1  registered one-cycle pulse after a taken redirect
- misalign_err  out  1  sticky flag: misaligned taken target seen
- br_count  out  CNT_W  branch instructions resolved (saturating)
- taken_count  out  CNT_W  taken branches (saturating)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, flush=0, misalign_err=0, br_count=0, taken_count=0. Assertion mid-operation clears everything immediately. The first update is on the first rising edge after deassertion.
- Update condition: eval = br_valid & !stall & br_type in 1..4.
- Taken decode:
  - B: always taken.
  - CBZ: taken when cmp_val==0.
  - CBNZ: taken when cmp_val!=0.
  - B.cond, by br_cond: 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !(C&!Z); 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE !(!Z&(N==V)); 14, 15 always.
- Target: tgt = pc_cur + (se_off << SHIFT), computed modulo 2^XLEN. Overflow wraps silently and the shifted-out high bits are discarded.
- Misaligned: eval & taken & tgt[ALIGN-1:0]!=0. Branch is suppressed and treated as not taken. misalign_err is set next edge and stays set until reset. Counters count the instruction as a branch but not as taken.
- Next PC, one edge of latency, registered:
  - stall=1: pc holds, counters hold, flush=0.
  - else if eval & taken & !misaligned: pc<=tgt, flush<=1, taken_count++.
  - else: pc<=pc+INC (wraps modulo 2^XLEN), flush<=0.
- br_count increments on every eval cycle.
- flush lasts exactly one cycle per taken branch. Back-to-back taken branches produce back-to-back flush pulses.
- stall together with br_valid: the branch is not resolved and nothing is counted. Upstream must hold the request until stall drops.
- Counters saturate at 2^CNT_W−1 and never wrap.
- br_type 0 or 5–7 with br_valid=1: sequential, not counted.

Test Plan:
- Reset: hold rst_n=0 with RESET_PC=0x1000 -> pc=0x1000, all other outputs 0. Deassert, no branches for 3 cycles -> pc 0x1004, 0x1008, 0x100C.
- B: pc_cur=0x2000, se_off=−4 (0xFFFF_FFFF_FFFF_FFFC) -> next pc=0x1FF0, flush=1 for one cycle, br_count=1, taken_count=1.
- CBZ/CBNZ: cmp_val=0, off=8, pc_cur=0x100 -> CBZ to 0x120. Same for CBNZ -> not taken, pc+4, flush=0. br_count=2, taken_count=1.
- B.cond sweep: all 16 codes × all 16 flag combinations against the table. Check taken/not taken for each, e.g. GT with N=1,V=1,Z=0 -> taken; LE with Z=1 -> taken.
- Stall and wrap:
  - stall=1 with B valid for 3 cycles -> pc frozen, counters unchanged, no flush.
  - pc=0xFFFF_FFFF_FFFF_FFFC, no branch -> next pc=0.
- Misalign and saturation:
  - SHIFT=0, B with off=2 -> no redirect, pc+4, misalign_err=1 and stays set.
  - CNT_W=4: 20 taken branches -> both counters =15.
  - Assert rst_n mid-stream -> all cleared asynchronously.

Source files
------------

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: architectural PC register and branch resolver.
// Resolves B, CBZ/CBNZ and B.cond and redirects fetch one edge later.
// Also provides a one-cycle flush pulse, a sticky misaligned-target flag
// and saturating branch/taken counters.
module branch_pc_unit #(
    parameter int              XLEN     = 64,
    parameter int              SHIFT    = 2,
    parameter int              INC      = 4,
    parameter int              ALIGN    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic [3:0]       br_cond,
    input  logic [3:0]       flags,
    input  logic [XLEN-1:0]  cmp_val,
    input  logic [XLEN-1:0]  pc_cur,
    input  logic [XLEN-1:0]  se_off,
    output logic [XLEN-1:0]  pc,
    output logic             flush,
    output logic             misalign_err,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_B    = 3'd1,
        BR_CBZ  = 3'd2,
        BR_CBNZ = 3'd3,
        BR_COND = 3'd4
    } br_type_e;

    // Low-bit mask that a legal target must leave clear (zero when ALIGN=0).
    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN) - XLEN'(1);
    localparam logic [XLEN-1:0] PC_INC     = XLEN'(INC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic            flag_n, flag_z, flag_c, flag_v;
    logic            cond_hit;
    logic            eval;
    logic            taken;
    logic [XLEN-1:0] off_sh;
    logic [XLEN-1:0] tgt;
    logic            tgt_bad;
    logic            redirect;
    logic            misalign_hit;

    assign {flag_n, flag_z, flag_c, flag_v} = flags;

    // Condition-code evaluation for B.cond against the current NZCV flags.
    always_comb begin
        cond_hit = 1'b0;
        case (br_cond)
            4'd0:    cond_hit = flag_z;
            4'd1:    cond_hit = !flag_z;
            4'd2:    cond_hit = flag_c;
            4'd3:    cond_hit = !flag_c;
            4'd4:    cond_hit = flag_n;
            4'd5:    cond_hit = !flag_n;
            4'd6:    cond_hit = flag_v;
            4'd7:    cond_hit = !flag_v;
            4'd8:    cond_hit = flag_c && !flag_z;
            4'd9:    cond_hit = !(flag_c && !flag_z);
            4'd10:   cond_hit = (flag_n == flag_v);
            4'd11:   cond_hit = (flag_n != flag_v);
            4'd12:   cond_hit = !flag_z && (flag_n == flag_v);
            4'd13:   cond_hit = !(!flag_z && (flag_n == flag_v));
            default: cond_hit = 1'b1;
        endcase
    end

    // Branch-type decode: which slots are real branches and whether they go.
    always_comb begin
        eval  = 1'b0;
        taken = 1'b0;
        case (br_type)
            BR_B: begin
                eval  = 1'b1;
                taken = 1'b1;
            end
            BR_CBZ: begin
                eval  = 1'b1;
                taken = (cmp_val == '0);
            end
            BR_CBNZ: begin
                eval  = 1'b1;
                taken = (cmp_val != '0);
            end
            BR_COND: begin
                eval  = 1'b1;
                taken = cond_hit;
            end
            default: begin
                eval  = 1'b0;
                taken = 1'b0;
            end
        endcase
        // A stalled or empty slot is neither resolved nor counted.
        eval  = eval && br_valid && !stall;
        taken = taken && eval;
    end

    // Target wraps modulo 2^XLEN; bits shifted past the top are dropped.
    assign off_sh       = se_off << SHIFT;
    assign tgt          = pc_cur + off_sh;
    assign tgt_bad      = |(tgt & ALIGN_MASK);
    assign redirect     = taken && !tgt_bad;
    assign misalign_hit = taken && tgt_bad;

    // Fetch PC and flush pulse: hold on stall, redirect on a good taken branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            flush <= 1'b0;
        end else if (stall) begin
            flush <= 1'b0;
        end else if (redirect) begin
            pc    <= tgt;
            flush <= 1'b1;
        end else begin
            pc    <= pc + PC_INC;
            flush <= 1'b0;
        end
    end

    // Sticky misaligned-target flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (misalign_hit) begin
            misalign_err <= 1'b1;
        end
    end

    // Saturating counters: every resolved branch, and redirects only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count    <= '0;
            taken_count <= '0;
        end else begin
            if (eval && br_count != CNT_MAX) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (redirect && taken_count != CNT_MAX) begin
                taken_count <= taken_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Testbench for branch_pc_unit: two instances (word-shift/32-bit counters and
// byte-offset/4-bit counters) share stimulus and are checked every cycle
// against an abstract model, plus a vector table and directed sequences.
module tb_branch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, br_valid;
    logic [2:0]  br_type;
    logic [3:0]  br_cond, flags;
    logic [63:0] cmp_val, pc_cur, se_off;

    logic [63:0] pc_a, pc_b;
    logic        flush_a, flush_b, mis_a, mis_b;
    logic [31:0] brc_a, tkc_a;
    logic [3:0]  brc_b, tkc_b;

    always #5 clk = ~clk;

    branch_pc_unit #(.XLEN(64), .SHIFT(2), .INC(4), .ALIGN(2),
                     .RESET_PC(64'h1000), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid),
        .br_type(br_type), .br_cond(br_cond), .flags(flags),
        .cmp_val(cmp_val), .pc_cur(pc_cur), .se_off(se_off),
        .pc(pc_a), .flush(flush_a), .misalign_err(mis_a),
        .br_count(brc_a), .taken_count(tkc_a));

    branch_pc_unit #(.XLEN(64), .SHIFT(0), .INC(4), .ALIGN(2),
                     .RESET_PC(64'h1000), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid),
        .br_type(br_type), .br_cond(br_cond), .flags(flags),
        .cmp_val(cmp_val), .pc_cur(pc_cur), .se_off(se_off),
        .pc(pc_b), .flush(flush_b), .misalign_err(mis_b),
        .br_count(brc_b), .taken_count(tkc_b));

    int n_chk = 0;
    int n_err = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    logic [63:0] m_pc[2];
    bit          m_fl[2];
    bit          m_ms[2];
    longint      m_bc[2];
    longint      m_tc[2];
    int          m_sh[2] = '{2, 0};
    int          m_cw[2] = '{32, 4};

    typedef struct {
        logic [2:0]  typ;
        logic [3:0]  cnd;
        logic [3:0]  flg;
        logic [63:0] cmp;
        logic [63:0] pcc;
        logic [63:0] off;
        bit          counted;
        bit          exp_tk;
        logic [63:0] exp_tgt;
    } vec_t;

    vec_t vt[10];

    // Conditions come in pairs: odd codes are the negation of the even one.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v, r;
        {n, z, cc, v} = f;
        if (c >= 14) return 1'b1;
        case (c >> 1)
            0: r = z;
            1: r = cc;
            2: r = n;
            3: r = v;
            4: r = cc && !z;
            5: r = (n == v);
            default: r = !z && (n == v);
        endcase
        return c[0] ? !r : r;
    endfunction

    function automatic bit model_taken();
        case (br_type)
            3'd1: return 1'b1;
            3'd2: return cmp_val == 64'd0;
            3'd3: return cmp_val != 64'd0;
            3'd4: return cond_ok(br_cond, flags);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 64'h1000;
            m_fl[i] = 1'b0;
            m_ms[i] = 1'b0;
            m_bc[i] = 0;
            m_tc[i] = 0;
        end
    endtask

    task automatic model_step();
        longint      mx;
        logic [63:0] tgt;
        bit          ev, tk, bad;
        for (int i = 0; i < 2; i++) begin
            mx  = (longint'(1) << m_cw[i]) - 1;
            tgt = pc_cur + (se_off << m_sh[i]);
            ev  = br_valid && !stall && br_type >= 3'd1 && br_type <= 3'd4;
            tk  = ev && model_taken();
            bad = tk && (tgt % 4 != 0);
            if (stall) begin
                m_fl[i] = 1'b0;
            end else if (tk && !bad) begin
                m_pc[i] = tgt;
                m_fl[i] = 1'b1;
                if (m_tc[i] < mx) m_tc[i]++;
            end else begin
                m_pc[i] = m_pc[i] + 64'd4;
                m_fl[i] = 1'b0;
            end
            if (ev && m_bc[i] < mx) m_bc[i]++;
            if (bad) m_ms[i] = 1'b1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("pc_a",    pc_a,          m_pc[0]);
        chk("flush_a", 64'(flush_a),  64'(m_fl[0]));
        chk("mis_a",   64'(mis_a),    64'(m_ms[0]));
        chk("brc_a",   64'(brc_a),    m_bc[0]);
        chk("tkc_a",   64'(tkc_a),    m_tc[0]);
        chk("pc_b",    pc_b,          m_pc[1]);
        chk("flush_b", 64'(flush_b),  64'(m_fl[1]));
        chk("mis_b",   64'(mis_b),    64'(m_ms[1]));
        chk("brc_b",   64'(brc_b),    m_bc[1]);
        chk("tkc_b",   64'(tkc_b),    m_tc[1]);
    endtask

    task automatic drive(input bit st, input bit v, input logic [2:0] t,
                         input logic [3:0] c, input logic [3:0] f,
                         input logic [63:0] cm, input logic [63:0] pcc,
                         input logic [63:0] off);
        stall = st; br_valid = v; br_type = t; br_cond = c; flags = f;
        cmp_val = cm; pc_cur = pcc; se_off = off;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 64'd0, 64'd0, 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        check_all();
    endtask

    // Assert reset between edges; outputs must clear before the next edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_mis_b", 64'(mis_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] prev, pa;
        longint      ba, ta;
        int          bc, tc, o;

        vt[0] = '{3'd1, 4'd0,  4'b0000, 64'd0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 64'h1FF0};
        vt[1] = '{3'd2, 4'd0,  4'b0000, 64'd0, 64'h100,  64'd8,  1, 1, 64'h120};
        vt[2] = '{3'd3, 4'd0,  4'b0000, 64'd0, 64'h100,  64'd8,  1, 0, 64'd0};
        vt[3] = '{3'd4, 4'd12, 4'b1001, 64'd0, 64'h400,  64'd4,  1, 1, 64'h410};
        vt[4] = '{3'd4, 4'd13, 4'b0100, 64'd0, 64'h400,  64'd4,  1, 1, 64'h410};
        vt[5] = '{3'd4, 4'd0,  4'b0000, 64'd0, 64'h400,  64'd4,  1, 0, 64'd0};
        vt[6] = '{3'd4, 4'd8,  4'b0010, 64'd0, 64'h500,  64'd2,  1, 1, 64'h508};
        vt[7] = '{3'd4, 4'd11, 4'b1000, 64'd0, 64'h500,  64'd3,  1, 1, 64'h50C};
        vt[8] = '{3'd4, 4'd7,  4'b0001, 64'd0, 64'h500,  64'd3,  1, 0, 64'd0};
        vt[9] = '{3'd6, 4'd0,  4'b0000, 64'd0, 64'h600,  64'd4,  0, 0, 64'd0};

        // Reset state and sequential fetch
        idle();
        model_reset();
        #12;
        check_all();
        chk("reset_pc", pc_a, 64'h1000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("seq_pc", pc_a, 64'h1000 + 64'(4 * k));
        end

        // Vector table
        bc = 0;
        tc = 0;
        for (int j = 0; j < 10; j++) begin
            prev = m_pc[0];
            drive(1'b0, 1'b1, vt[j].typ, vt[j].cnd, vt[j].flg, vt[j].cmp,
                  vt[j].pcc, vt[j].off);
            step();
            if (vt[j].counted) bc++;
            if (vt[j].exp_tk) tc++;
            chk("vec_pc",    pc_a, vt[j].exp_tk ? vt[j].exp_tgt : prev + 64'd4);
            chk("vec_flush", 64'(flush_a), 64'(vt[j].exp_tk));
            chk("vec_brc",   64'(brc_a), 64'(bc));
            chk("vec_tkc",   64'(tkc_a), 64'(tc));
        end

        // Full B.cond sweep
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                drive(1'b0, 1'b1, 3'd4, 4'(c), 4'(f), 64'd0, 64'h800, 64'h10);
                step();
            end
        end

        // Stall with a valid B: nothing moves
        pa = m_pc[0];
        ba = m_bc[0];
        ta = m_tc[0];
        drive(1'b1, 1'b1, 3'd1, 4'd0, 4'd0, 64'd0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFC);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc",    pc_a, pa);
            chk("stall_brc",   64'(brc_a), 64'(ba));
            chk("stall_tkc",   64'(tkc_a), 64'(ta));
            chk("stall_flush", 64'(flush_a), 64'd0);
        end

        // PC wraps past the top of the address space
        drive(1'b0, 1'b1, 3'd1, 4'd0, 4'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3);
        step();
        chk("wrap_tgt", pc_a, 64'hFFFF_FFFF_FFFF_FFFC);
        idle();
        step();
        chk("wrap_pc", pc_a, 64'd0);

        // Misaligned target on the byte-offset instance, then sticky
        do_reset();
        drive(1'b0, 1'b1, 3'd1, 4'd0, 4'd0, 64'd0, 64'h100, 64'd2);
        step();
        chk("mis_set",   64'(mis_b), 64'd1);
        chk("mis_pc",    pc_b, 64'h1004);
        chk("mis_flush", 64'(flush_b), 64'd0);
        chk("mis_brc",   64'(brc_b), 64'd1);
        chk("mis_tkc",   64'(tkc_b), 64'd0);
        idle();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mis_sticky", 64'(mis_b), 64'd1);
        end

        // Mid-stream asynchronous reset with a branch in flight
        drive(1'b0, 1'b1, 3'd1, 4'd0, 4'd0, 64'd0, 64'h100, 64'd2);
        do_reset();

        // Counter saturation
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b1, 3'd1, 4'd0, 4'd0, 64'd0, 64'h3000, 64'd8);
            step();
        end
        chk("sat_brc_b", 64'(brc_b), 64'd15);
        chk("sat_tkc_b", 64'(tkc_b), 64'd15);
        chk("sat_brc_a", 64'(brc_a), 64'd20);
        chk("sat_tkc_a", 64'(tkc_a), 64'd20);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            o = int'($urandom_range(0, 2000)) - 1000;
            pa = {$urandom, $urandom};
            if ($urandom % 8 != 0) pa[1:0] = 2'b00;
            drive($urandom % 5 == 0, $urandom % 4 != 0, 3'($urandom % 8),
                  4'($urandom), 4'($urandom),
                  ($urandom % 3 == 0) ? 64'd0 : {$urandom, $urandom},
                  pa,
                  ($urandom % 10 == 0) ? {$urandom, $urandom} : 64'(longint'(o)));
            step();
        end
        do_reset();
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
